// File: rtl/branch_trap_sequencer_pkg.sv
// Shared encodings for the branch/trap sequencer: condition codes, window
// register indices, software-trap base and the trap-entry FSM states.
package branch_trap_sequencer_pkg;

  localparam logic [3:0] COND_BA    = 4'b1000;
  localparam logic [3:0] COND_BN    = 4'b0000;
  localparam logic [4:0] REG_L1     = 5'd17;
  localparam logic [4:0] REG_L2     = 5'd18;
  localparam logic [7:0] TT_SW_BASE = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    SAVE_PC,
    SAVE_NPC,
    VECTOR,
    ERROR
  } trap_state_e;

  // Window decrement on trap entry; CWP 0 wraps to the top window.
  function automatic logic [4:0] cwp_dec(input logic [4:0] cwp, input int nwin);
    logic [4:0] r;
    if (cwp == 5'd0) r = 5'(nwin - 1);
    else             r = cwp - 5'd1;
    return r;
  endfunction

endpackage

// File: rtl/branch_trap_sequencer_trap_entry_fsm.sv
// Trap-entry sequencer: latches the trap context at accept and walks
// ENTRY -> SAVE_PC -> SAVE_NPC -> VECTOR, or parks in ERROR when ET=0.
module trap_entry_fsm
  import branch_trap_sequencer_pkg::*;
#(
  parameter int NWINDOWS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic [31:0] npc,
  input  logic [4:0]  cwp,
  input  logic        s,
  input  logic        et,
  input  logic [19:0] tba,
  input  logic [6:0]  trap_num,
  output logic        busy,
  output logic        error_mode,
  output logic        psr_we,
  output logic [4:0]  psr_cwp_new,
  output logic        psr_s_new,
  output logic        psr_ps_new,
  output logic        psr_et_new,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        tbr_we,
  output logic [7:0]  tbr_tt,
  output logic        pc_load,
  output logic [31:0] new_pc,
  output logic [31:0] new_npc
);

  trap_state_e state, state_nxt;
  logic [31:0] pc_l, npc_l;
  logic [4:0]  cwp_l;
  logic        s_l, et_l;
  logic [19:0] tba_l;
  logic [6:0]  tn_l;
  logic [7:0]  tt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pc_l  <= '0;
      npc_l <= '0;
      cwp_l <= '0;
      s_l   <= 1'b0;
      et_l  <= 1'b0;
      tba_l <= '0;
      tn_l  <= '0;
    end else begin
      state <= state_nxt;
      if (start && state == IDLE) begin
        pc_l  <= pc;
        npc_l <= npc;
        cwp_l <= cwp;
        s_l   <= s;
        et_l  <= et;
        tba_l <= tba;
        tn_l  <= trap_num;
      end
    end
  end

  assign tt = TT_SW_BASE | {1'b0, tn_l};

  // Outputs decode only the state register and the latched context.
  always_comb begin
    state_nxt   = state;
    busy        = (state != IDLE);
    error_mode  = 1'b0;
    psr_we      = 1'b0;
    psr_cwp_new = '0;
    psr_s_new   = 1'b0;
    psr_ps_new  = 1'b0;
    psr_et_new  = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    tbr_we      = 1'b0;
    tbr_tt      = '0;
    pc_load     = 1'b0;
    new_pc      = '0;
    new_npc     = '0;
    case (state)
      IDLE: if (start) state_nxt = ENTRY;
      ENTRY: begin
        if (!et_l) begin
          error_mode = 1'b1;
          state_nxt  = ERROR;
        end else begin
          psr_we      = 1'b1;
          psr_cwp_new = cwp_dec(cwp_l, NWINDOWS);
          psr_s_new   = 1'b1;
          psr_ps_new  = s_l;
          psr_et_new  = 1'b0;
          state_nxt   = SAVE_PC;
        end
      end
      SAVE_PC: begin
        rf_we     = 1'b1;
        rf_waddr  = REG_L1;
        rf_wdata  = pc_l;
        state_nxt = SAVE_NPC;
      end
      SAVE_NPC: begin
        rf_we     = 1'b1;
        rf_waddr  = REG_L2;
        rf_wdata  = npc_l;
        state_nxt = VECTOR;
      end
      VECTOR: begin
        tbr_we    = 1'b1;
        tbr_tt    = tt;
        pc_load   = 1'b1;
        new_pc    = {tba_l, tt, 4'b0000};
        new_npc   = {tba_l, tt, 4'b0100};
        state_nxt = IDLE;
      end
      ERROR: error_mode = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/branch_trap_sequencer.sv
// Delayed-branch resolution for Bicc plus dispatch of taken Ticc into the
// trap-entry sequencer; merges both onto the PC/nPC load port.
module branch_trap_sequencer
  import branch_trap_sequencer_pkg::*;
#(
  parameter int NWINDOWS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic        is_branch,
  input  logic        is_trap,
  input  logic        BCOND,
  input  logic        TCOND,
  input  logic        annul_bit,
  input  logic [3:0]  cond,
  input  logic [21:0] disp22,
  input  logic [6:0]  trap_num,
  input  logic [31:0] pc,
  input  logic [31:0] npc,
  input  logic [4:0]  psr_cwp,
  input  logic        psr_s,
  input  logic        psr_et,
  input  logic [19:0] tba,
  output logic        busy,
  output logic        pc_load,
  output logic [31:0] new_pc,
  output logic [31:0] new_npc,
  output logic        annul_next,
  output logic        psr_we,
  output logic [4:0]  psr_cwp_new,
  output logic        psr_s_new,
  output logic        psr_ps_new,
  output logic        psr_et_new,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        tbr_we,
  output logic [7:0]  tbr_tt,
  output logic        error_mode
);

  logic        accept, trap_go, br_go;
  logic [31:0] br_target;
  logic        br_load, br_annul;
  logic [31:0] br_pc, br_npc;
  logic        fsm_pc_load;
  logic [31:0] fsm_new_pc, fsm_new_npc;

  assign accept    = instr_valid && !busy;
  assign trap_go   = accept && is_trap && TCOND;
  assign br_go     = accept && is_branch && !trap_go;
  assign br_target = pc + {{8{disp22[21]}}, disp22, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      br_load  <= 1'b0;
      br_pc    <= '0;
      br_npc   <= '0;
      br_annul <= 1'b0;
    end else begin
      br_load  <= br_go;
      br_pc    <= br_go ? npc : '0;
      br_npc   <= !br_go ? '0 : (BCOND ? br_target : npc + 32'd4);
      // Taken branches only annul the slot when unconditional (BA,a).
      br_annul <= br_go && annul_bit && (!BCOND || cond == COND_BA);
    end
  end

  trap_entry_fsm #(.NWINDOWS(NWINDOWS)) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .start       (trap_go),
    .pc          (pc),
    .npc         (npc),
    .cwp         (psr_cwp),
    .s           (psr_s),
    .et          (psr_et),
    .tba         (tba),
    .trap_num    (trap_num),
    .busy        (busy),
    .error_mode  (error_mode),
    .psr_we      (psr_we),
    .psr_cwp_new (psr_cwp_new),
    .psr_s_new   (psr_s_new),
    .psr_ps_new  (psr_ps_new),
    .psr_et_new  (psr_et_new),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .tbr_we      (tbr_we),
    .tbr_tt      (tbr_tt),
    .pc_load     (fsm_pc_load),
    .new_pc      (fsm_new_pc),
    .new_npc     (fsm_new_npc)
  );

  // Branch and vector loads never coincide: branches cannot be accepted while busy.
  assign pc_load    = br_load | fsm_pc_load;
  assign new_pc     = br_pc | fsm_new_pc;
  assign new_npc    = br_npc | fsm_new_npc;
  assign annul_next = br_annul;

endmodule

// File: tb/tb_branch_trap_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed expected events per port,
// a negedge monitor pops and compares whenever a strobe is seen.
module tb_branch_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, is_branch, is_trap, BCOND, TCOND, annul_bit;
  logic [3:0]  cond;
  logic [21:0] disp22;
  logic [6:0]  trap_num;
  logic [31:0] pc, npc;
  logic [4:0]  psr_cwp;
  logic        psr_s, psr_et;
  logic [19:0] tba;
  logic        busy, pc_load, annul_next, psr_we, psr_s_new, psr_ps_new, psr_et_new;
  logic        rf_we, tbr_we, error_mode;
  logic [31:0] new_pc, new_npc, rf_wdata;
  logic [4:0]  psr_cwp_new, rf_waddr;
  logic [7:0]  tbr_tt;

  branch_trap_sequencer #(.NWINDOWS(32)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .is_branch(is_branch),
    .is_trap(is_trap), .BCOND(BCOND), .TCOND(TCOND), .annul_bit(annul_bit),
    .cond(cond), .disp22(disp22), .trap_num(trap_num), .pc(pc), .npc(npc),
    .psr_cwp(psr_cwp), .psr_s(psr_s), .psr_et(psr_et), .tba(tba),
    .busy(busy), .pc_load(pc_load), .new_pc(new_pc), .new_npc(new_npc),
    .annul_next(annul_next), .psr_we(psr_we), .psr_cwp_new(psr_cwp_new),
    .psr_s_new(psr_s_new), .psr_ps_new(psr_ps_new), .psr_et_new(psr_et_new),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .tbr_we(tbr_we), .tbr_tt(tbr_tt), .error_mode(error_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
  } ev_t;

  ev_t q_pc[$], q_psr[$], q_rf[$], q_tbr[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: strobe seen with no expected event (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (pc_load) begin
        if (q_pc.size() == 0) unexpected("pc_load");
        else begin
          e = q_pc.pop_front();
          chk("pc_load cycle", cyc, e.cyc);
          chk("new_pc", new_pc, e.a);
          chk("new_npc", new_npc, e.b);
          chk("annul_next", {31'd0, annul_next}, {31'd0, e.c});
        end
      end else if (new_pc != 0 || new_npc != 0 || annul_next) unexpected("pc data without pc_load");
      if (psr_we) begin
        if (q_psr.size() == 0) unexpected("psr_we");
        else begin
          e = q_psr.pop_front();
          chk("psr cycle", cyc, e.cyc);
          chk("psr_cwp_new", {27'd0, psr_cwp_new}, e.a);
          chk("psr ps/s/et", {29'd0, psr_ps_new, psr_s_new, psr_et_new}, e.b);
        end
      end else if (psr_cwp_new != 0 || psr_s_new || psr_ps_new || psr_et_new) unexpected("psr data without psr_we");
      if (rf_we) begin
        if (q_rf.size() == 0) unexpected("rf_we");
        else begin
          e = q_rf.pop_front();
          chk("rf cycle", cyc, e.cyc);
          chk("rf_waddr", {27'd0, rf_waddr}, e.a);
          chk("rf_wdata", rf_wdata, e.b);
        end
      end else if (rf_waddr != 0 || rf_wdata != 0) unexpected("rf data without rf_we");
      if (tbr_we) begin
        if (q_tbr.size() == 0) unexpected("tbr_we");
        else begin
          e = q_tbr.pop_front();
          chk("tbr cycle", cyc, e.cyc);
          chk("tbr_tt", {24'd0, tbr_tt}, e.a);
        end
      end else if (tbr_tt != 0) unexpected("tbr data without tbr_we");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 0; is_branch = 0; is_trap = 0; BCOND = 0; TCOND = 0;
    annul_bit = 0; cond = 0; disp22 = 0; trap_num = 0; pc = 0; npc = 0;
    psr_cwp = 0; psr_s = 0; psr_et = 0; tba = 0;
  endtask

  // Drives one Bicc for one cycle; exp values are hand-computed by the caller.
  task automatic do_branch(input logic [31:0] p, input logic [31:0] np, input logic [21:0] d,
                           input logic a, input logic [3:0] c, input logic bc,
                           input logic [31:0] exp_npc, input logic exp_an, input bit expect_it);
    idle();
    instr_valid = 1; is_branch = 1; BCOND = bc; annul_bit = a; cond = c;
    disp22 = d; pc = p; npc = np;
    if (expect_it) q_pc.push_back('{cyc + 1, np, exp_npc, exp_an});
    step();
  endtask

  task automatic do_trap(input logic [31:0] p, input logic [31:0] np, input logic [4:0] cw,
                         input logic s, input logic et, input logic [19:0] tb,
                         input logic [6:0] tn, input logic also_branch);
    idle();
    instr_valid = 1; is_trap = 1; TCOND = 1; is_branch = also_branch; BCOND = also_branch;
    pc = p; npc = np; psr_cwp = cw; psr_s = s; psr_et = et; tba = tb; trap_num = tn;
    step();
  endtask

  initial begin
    int t;
    idle();
    reset = 1;
    repeat (3) step();
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset pc_load", {31'd0, pc_load}, 0);
    chk("reset error_mode", {31'd0, error_mode}, 0);
    chk("reset psr_we", {31'd0, psr_we}, 0);
    chk("reset rf_we", {31'd0, rf_we}, 0);
    chk("reset tbr_we", {31'd0, tbr_we}, 0);
    chk("reset new_pc", new_pc, 0);
    reset = 0;
    mon_en = 1;

    // Back-to-back branches, one per cycle.
    do_branch(32'h1000, 32'h1004, 22'h3FFFFE, 0, 4'b1001, 1, 32'h0000_0FF8, 0, 1);
    do_branch(32'h2000, 32'h2004, 22'h000005, 1, 4'b1001, 0, 32'h0000_2008, 1, 1);
    do_branch(32'h4000, 32'h4004, 22'h000004, 1, 4'b1000, 1, 32'h0000_4010, 1, 1);
    do_branch(32'h5000, 32'h5004, 22'h000100, 1, 4'b1001, 1, 32'h0000_5400, 0, 1);
    do_branch(32'hFFFF_FFF0, 32'hFFFF_FFF4, 22'h000008, 0, 4'b1000, 1, 32'h0000_0010, 0, 1);
    do_branch(32'hFFFF_FFF8, 32'hFFFF_FFFC, 22'h000000, 0, 4'b0000, 0, 32'h0000_0000, 0, 1);
    do_branch(32'h0000_0100, 32'h0000_0104, 22'h000000, 1, 4'b0000, 0, 32'h0000_0108, 1, 1);
    do_branch(32'h0100_0000, 32'h0100_0004, 22'h200000, 0, 4'b1001, 1, 32'h0080_0000, 0, 1);

    // Non-control instruction and untaken Ticc produce nothing.
    idle(); instr_valid = 1; pc = 32'h9000; npc = 32'h9004; step();
    idle(); instr_valid = 1; is_trap = 1; TCOND = 0; psr_et = 1; step();
    idle(); step();
    chk("untaken ticc busy", {31'd0, busy}, 0);

    // Ticc 0x05 with is_branch also high; trap wins, branch at T+2 ignored.
    t = cyc;
    q_psr.push_back('{t + 1, 32'd31, 32'b010, 0});
    q_rf.push_back('{t + 2, 32'd17, 32'h3000, 0});
    q_rf.push_back('{t + 3, 32'd18, 32'h3004, 0});
    q_tbr.push_back('{t + 4, 32'h85, 0, 0});
    q_pc.push_back('{t + 4, 32'h0004_0850, 32'h0004_0854, 0});
    do_trap(32'h3000, 32'h3004, 5'd0, 0, 1, 20'h00040, 7'h05, 1);
    chk("trap busy T+1", {31'd0, busy}, 1);
    do_branch(32'hA000, 32'hA004, 22'h1, 0, 4'b1001, 1, 0, 0, 0);
    chk("trap busy T+2", {31'd0, busy}, 1);
    idle(); step();
    chk("trap busy T+3", {31'd0, busy}, 1);
    step();
    chk("trap busy T+4", {31'd0, busy}, 1);
    step();
    chk("trap busy T+5", {31'd0, busy}, 0);
    do_branch(32'h7000, 32'h7004, 22'h000001, 0, 4'b1001, 1, 32'h0000_7004, 0, 1);

    // CWP=5, S=1, largest tt and tba.
    idle(); step();
    t = cyc;
    q_psr.push_back('{t + 1, 32'd4, 32'b110, 0});
    q_rf.push_back('{t + 2, 32'd17, 32'h1234_5678, 0});
    q_rf.push_back('{t + 3, 32'd18, 32'h1234_567C, 0});
    q_tbr.push_back('{t + 4, 32'hFF, 0, 0});
    q_pc.push_back('{t + 4, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 0});
    do_trap(32'h1234_5678, 32'h1234_567C, 5'd5, 1, 1, 20'hFFFFF, 7'h7F, 0);
    idle();
    repeat (5) step();

    // Reset during SAVE_PC: nothing after T+2.
    t = cyc;
    q_psr.push_back('{t + 1, 32'd2, 32'b010, 0});
    q_rf.push_back('{t + 2, 32'd17, 32'h6000, 0});
    do_trap(32'h6000, 32'h6004, 5'd3, 0, 1, 20'h00001, 7'h01, 0);
    idle(); step();
    reset = 1; step();
    reset = 0;
    chk("midreset busy", {31'd0, busy}, 0);
    chk("midreset rf_we", {31'd0, rf_we}, 0);
    chk("midreset pc_load", {31'd0, pc_load}, 0);
    chk("midreset tbr_we", {31'd0, tbr_we}, 0);
    repeat (4) step();

    // ET=0: error mode from T+1 until reset, branches ignored.
    do_trap(32'h8000, 32'h8004, 5'd7, 1, 0, 20'h00002, 7'h10, 0);
    chk("err T+1 error_mode", {31'd0, error_mode}, 1);
    chk("err T+1 busy", {31'd0, busy}, 1);
    do_branch(32'hB000, 32'hB004, 22'h1, 0, 4'b1001, 1, 0, 0, 0);
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("err persists", {31'd0, error_mode}, 1);
    end
    reset = 1; step();
    reset = 0;
    chk("err cleared", {31'd0, error_mode}, 0);
    chk("err cleared busy", {31'd0, busy}, 0);
    do_branch(32'hC000, 32'hC004, 22'h3FFFFF, 1, 4'b1000, 1, 32'h0000_BFFC, 1, 1);

    idle();
    repeat (4) step();
    chk("pending pc events", q_pc.size(), 0);
    chk("pending psr events", q_psr.size(), 0);
    chk("pending rf events", q_rf.size(), 0);
    chk("pending tbr events", q_tbr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
